// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   CNT_W       : width of the write-acknowledge wait counter
//   gid_w()     : width of a requester index for a given requester count
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned CNT_W = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned gid_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted last; search starts at last_grant+1
//   mask       : requests with a 0 here are excluded from the search
//   any_req    : at least one unmasked request is present
//   winner     : first unmasked request searching upward (mod NUM_REQ)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GID_W   = gid_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_grant,
  input  logic [NUM_REQ-1:0] mask,
  output logic               any_req,
  output logic [GID_W-1:0]   winner
);

  logic [NUM_REQ-1:0] eff_c;
  logic [GID_W-1:0]   idx_c;
  logic               found_c;

  // Walk indices last_grant+1 .. last_grant+NUM_REQ and keep the first hit.
  always_comb begin
    eff_c   = req & mask;
    any_req = |eff_c;
    winner  = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx_c = GID_W'((32'(last_grant) + off) % NUM_REQ);
      if (!found_c && eff_c[idx_c]) begin
        winner  = idx_c;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing the async FIFO write port.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   req_valid    : per-requester write request, held until its req_ready
//   req_data     : requester i data at [i*DATA_W +: DATA_W]
//   req_ready    : one-cycle pulse, requester's word accepted
//   fifo_full    : FIFO full flag (clk domain)
//   fifo_wack    : one-cycle pulse, FIFO consumed the current write
//   fifo_winc    : level-held write request toward the FIFO
//   fifo_wdata   : write data, stable while fifo_winc=1
//   grant_id     : current or last granted requester
//   busy         : FSM not in IDLE
//   timeout_err  : sticky, set on a write timeout
// Build option: FIFO_ARB_PRIO_EN gives requester 0 fixed highest priority.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  input  logic                        fifo_wack,
  output logic                        fifo_winc,
  output logic [DATA_W-1:0]           fifo_wdata,
  output logic [gid_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned GID_W = gid_w(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GID_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic                winc_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [GID_W-1:0]    gid_d;
  logic                busy_d;
  logic                terr_d;

  logic [NUM_REQ-1:0]  pick_mask;
  logic                prio_hit;
  logic                upd_last;
  logic                rr_any;
  logic [GID_W-1:0]    rr_win;
  logic                any_c;
  logic [GID_W-1:0]    win_c;
  logic [DATA_W-1:0]   win_data_c;

`ifdef FIFO_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  assign pick_mask = {{(NUM_REQ-1){1'b1}}, 1'b0};
  assign prio_hit  = req_valid[0];
  assign upd_last  = (grant_id != '0);
`else
  assign pick_mask = '1;
  assign prio_hit  = 1'b0;
  assign upd_last  = 1'b1;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .mask       (pick_mask),
    .any_req    (rr_any),
    .winner     (rr_win)
  );

  assign any_c = prio_hit | rr_any;
  assign win_c = prio_hit ? '0 : rr_win;

  // Select the winner's data word.
  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_c == GID_W'(i)) win_data_c = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ready_d = '0;
    winc_d  = fifo_winc;
    wdata_d = fifo_wdata;
    gid_d   = grant_id;
    terr_d  = timeout_err;

    unique case (state_q)
      ST_IDLE: begin
        if (any_c && !fifo_full) begin
          state_d = ST_WRITE;
          winc_d  = 1'b1;
          wdata_d = win_data_c;
          gid_d   = win_c;
          cnt_d   = '0;
        end
      end
      ST_WRITE: begin
        // Ack takes precedence over a coincident timeout.
        if (fifo_wack) begin
          state_d = ST_RELEASE;
          winc_d  = 1'b0;
          ready_d = NUM_REQ'(1) << grant_id;
          if (upd_last) last_d = grant_id;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RELEASE;
          winc_d  = 1'b0;
          terr_d  = 1'b1;
          if (upd_last) last_d = grant_id;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        winc_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= GID_W'(NUM_REQ - 1);
      req_ready   <= '0;
      fifo_winc   <= 1'b0;
      fifo_wdata  <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      req_ready   <= ready_d;
      fifo_winc   <= winc_d;
      fifo_wdata  <= wdata_d;
      grant_id    <= gid_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
    end
  end

endmodule
